// File: rtl/decode_ctrl_stage.sv
// RV32I control decoder feeding a registered ID/EX control slice.
// Combinational decode of id_instr_i, captured on the rising edge with flush > stall > load priority.
module decode_ctrl_stage #(
  parameter int XLEN            = 32,
  parameter bit SUPPORT_IMM_ALU = 1'b1,
  parameter bit SUPPORT_JUMP    = 1'b1,
  parameter bit SUPPORT_UPPER   = 1'b1,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid_i,
  input  logic [31:0]      id_instr_i,
  input  logic [XLEN-1:0]  id_pc_i,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic             ex_valid_o,
  output logic             ex_reg_write_o,
  output logic             ex_mem_write_o,
  output logic [1:0]       ex_result_src_o,
  output logic             ex_alu_src_o,
  output logic             ex_alu_src_a_o,
  output logic             ex_branch_o,
  output logic             ex_jump_o,
  output logic             ex_jalr_o,
  output logic [1:0]       ex_alu_op_o,
  output logic [2:0]       ex_imm_src_o,
  output logic [XLEN-1:0]  ex_imm_o,
  output logic [4:0]       ex_rd_o,
  output logic [4:0]       ex_rs1_o,
  output logic [4:0]       ex_rs2_o,
  output logic [2:0]       ex_funct3_o,
  output logic             ex_funct7b5_o,
  output logic [XLEN-1:0]  ex_pc_o,
  output logic             ex_illegal_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
    logic       alu_src;
    logic       alu_src_a;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic [1:0] alu_op;
    logic [2:0] imm_src;
    logic       illegal;
  } ctrl_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [31:0]        w_i;
  ctrl_t              w_ctrl;
  logic               w_has_imm;
  logic signed [31:0] w_imm32;
  logic [XLEN-1:0]    w_imm;

  assign w_i = id_instr_i;

  // Any opcode not matched by an enabled class stays all-zero and is flagged illegal.
  always_comb begin
    w_ctrl    = '0;
    w_has_imm = 1'b1;
    case (w_i[6:0])
      OP_LOAD:  begin w_ctrl.reg_write = 1'b1; w_ctrl.alu_src = 1'b1; w_ctrl.result_src = 2'b01; end
      OP_STORE: begin w_ctrl.mem_write = 1'b1; w_ctrl.alu_src = 1'b1; w_ctrl.imm_src = 3'b001; end
      OP_REG:   begin w_ctrl.reg_write = 1'b1; w_ctrl.alu_op = 2'b10; w_has_imm = 1'b0; end
      OP_BR:    begin w_ctrl.branch = 1'b1; w_ctrl.imm_src = 3'b010; w_ctrl.alu_op = 2'b01; end
      OP_IMM: begin
        if (SUPPORT_IMM_ALU) begin
          w_ctrl.reg_write = 1'b1; w_ctrl.alu_src = 1'b1; w_ctrl.alu_op = 2'b10;
        end else w_ctrl.illegal = 1'b1;
      end
      OP_JAL: begin
        if (SUPPORT_JUMP) begin
          w_ctrl.reg_write = 1'b1; w_ctrl.jump = 1'b1; w_ctrl.result_src = 2'b10;
          w_ctrl.imm_src = 3'b011;
        end else w_ctrl.illegal = 1'b1;
      end
      OP_JALR: begin
        if (SUPPORT_JUMP) begin
          w_ctrl.reg_write = 1'b1; w_ctrl.jump = 1'b1; w_ctrl.jalr = 1'b1;
          w_ctrl.alu_src = 1'b1; w_ctrl.result_src = 2'b10;
        end else w_ctrl.illegal = 1'b1;
      end
      OP_LUI: begin
        if (SUPPORT_UPPER) begin
          w_ctrl.reg_write = 1'b1; w_ctrl.alu_src = 1'b1; w_ctrl.imm_src = 3'b100;
          w_ctrl.alu_op = 2'b11;
        end else w_ctrl.illegal = 1'b1;
      end
      OP_AUIPC: begin
        if (SUPPORT_UPPER) begin
          w_ctrl.reg_write = 1'b1; w_ctrl.alu_src_a = 1'b1; w_ctrl.alu_src = 1'b1;
          w_ctrl.imm_src = 3'b100;
        end else w_ctrl.illegal = 1'b1;
      end
      default: w_ctrl.illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_imm32 = '0;
    if (w_has_imm && !w_ctrl.illegal) begin
      case (w_ctrl.imm_src)
        3'b001:  w_imm32 = {{20{w_i[31]}}, w_i[31:25], w_i[11:7]};
        3'b010:  w_imm32 = {{19{w_i[31]}}, w_i[31], w_i[7], w_i[30:25], w_i[11:8], 1'b0};
        3'b011:  w_imm32 = {{11{w_i[31]}}, w_i[31], w_i[19:12], w_i[20], w_i[30:21], 1'b0};
        3'b100:  w_imm32 = {w_i[31:12], 12'b0};
        default: w_imm32 = {{20{w_i[31]}}, w_i[31:20]};
      endcase
    end
  end

  assign w_imm = XLEN'(w_imm32);

  logic              r_valid;
  ctrl_t             r_ctrl;
  logic [XLEN-1:0]   r_imm;
  logic [4:0]        r_rd, r_rs1, r_rs2;
  logic [2:0]        r_funct3;
  logic              r_funct7b5;
  logic [XLEN-1:0]   r_pc;
  logic [CNT_W-1:0]  r_ill_cnt;
  logic              w_load, w_bubble;

  assign w_bubble = flush_i || (!stall_i && !id_valid_i);
  assign w_load   = !flush_i && !stall_i && id_valid_i;

  // ID/EX boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || w_bubble) begin
      r_valid <= 1'b0; r_ctrl <= '0; r_imm <= '0; r_rd <= '0; r_rs1 <= '0; r_rs2 <= '0;
      r_funct3 <= '0; r_funct7b5 <= 1'b0; r_pc <= '0;
    end else if (w_load) begin
      r_valid    <= 1'b1;
      r_ctrl     <= w_ctrl;
      r_imm      <= w_imm;
      r_rd       <= w_i[11:7];
      r_rs1      <= w_i[19:15];
      r_rs2      <= w_i[24:20];
      r_funct3   <= w_i[14:12];
      r_funct7b5 <= w_i[30];
      r_pc       <= id_pc_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ill_cnt <= '0;
    else if (w_load && w_ctrl.illegal) r_ill_cnt <= sat_inc(r_ill_cnt);
  end

  assign ex_valid_o      = r_valid;
  assign ex_reg_write_o  = r_ctrl.reg_write;
  assign ex_mem_write_o  = r_ctrl.mem_write;
  assign ex_result_src_o = r_ctrl.result_src;
  assign ex_alu_src_o    = r_ctrl.alu_src;
  assign ex_alu_src_a_o  = r_ctrl.alu_src_a;
  assign ex_branch_o     = r_ctrl.branch;
  assign ex_jump_o       = r_ctrl.jump;
  assign ex_jalr_o       = r_ctrl.jalr;
  assign ex_alu_op_o     = r_ctrl.alu_op;
  assign ex_imm_src_o    = r_ctrl.imm_src;
  assign ex_imm_o        = r_imm;
  assign ex_rd_o         = r_rd;
  assign ex_rs1_o        = r_rs1;
  assign ex_rs2_o        = r_rs2;
  assign ex_funct3_o     = r_funct3;
  assign ex_funct7b5_o   = r_funct7b5;
  assign ex_pc_o         = r_pc;
  assign ex_illegal_o    = r_ctrl.illegal;
  assign illegal_cnt_o   = r_ill_cnt;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Bench for decode_ctrl_stage: a default instance and one with jumps disabled and a 2-bit counter,
// both driven with the same directed stream and checked against a scoreboard queue.
module tb_decode_ctrl_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, id_valid, stall, flush;
  logic [31:0] instr, pc;

  typedef struct packed {
    logic valid, rw, mw; logic [1:0] rsrc; logic asrc, asrca, br, jmp, jalr;
    logic [1:0] aluop; logic [2:0] immsrc; logic [31:0] imm;
    logic [4:0] rd, rs1, rs2; logic [2:0] f3; logic f7; logic [31:0] pc; logic ill;
  } exp_t;

  typedef struct packed { exp_t a; exp_t b; logic [7:0] ca; logic [1:0] cb; } sb_t;

  logic a_valid, a_rw, a_mw, a_asrc, a_asrca, a_br, a_jmp, a_jalr, a_f7, a_ill;
  logic [1:0] a_rsrc, a_aluop; logic [2:0] a_immsrc, a_f3; logic [31:0] a_imm, a_pc;
  logic [4:0] a_rd, a_rs1, a_rs2; logic [7:0] a_cnt;
  logic b_valid, b_rw, b_mw, b_asrc, b_asrca, b_br, b_jmp, b_jalr, b_f7, b_ill;
  logic [1:0] b_rsrc, b_aluop; logic [2:0] b_immsrc, b_f3; logic [31:0] b_imm, b_pc;
  logic [4:0] b_rd, b_rs1, b_rs2; logic [1:0] b_cnt;

  decode_ctrl_stage u_a (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_instr_i(instr), .id_pc_i(pc),
    .stall_i(stall), .flush_i(flush), .ex_valid_o(a_valid), .ex_reg_write_o(a_rw),
    .ex_mem_write_o(a_mw), .ex_result_src_o(a_rsrc), .ex_alu_src_o(a_asrc),
    .ex_alu_src_a_o(a_asrca), .ex_branch_o(a_br), .ex_jump_o(a_jmp), .ex_jalr_o(a_jalr),
    .ex_alu_op_o(a_aluop), .ex_imm_src_o(a_immsrc), .ex_imm_o(a_imm), .ex_rd_o(a_rd),
    .ex_rs1_o(a_rs1), .ex_rs2_o(a_rs2), .ex_funct3_o(a_f3), .ex_funct7b5_o(a_f7),
    .ex_pc_o(a_pc), .ex_illegal_o(a_ill), .illegal_cnt_o(a_cnt));

  decode_ctrl_stage #(.SUPPORT_JUMP(1'b0), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_instr_i(instr), .id_pc_i(pc),
    .stall_i(stall), .flush_i(flush), .ex_valid_o(b_valid), .ex_reg_write_o(b_rw),
    .ex_mem_write_o(b_mw), .ex_result_src_o(b_rsrc), .ex_alu_src_o(b_asrc),
    .ex_alu_src_a_o(b_asrca), .ex_branch_o(b_br), .ex_jump_o(b_jmp), .ex_jalr_o(b_jalr),
    .ex_alu_op_o(b_aluop), .ex_imm_src_o(b_immsrc), .ex_imm_o(b_imm), .ex_rd_o(b_rd),
    .ex_rs1_o(b_rs1), .ex_rs2_o(b_rs2), .ex_funct3_o(b_f3), .ex_funct7b5_o(b_f7),
    .ex_pc_o(b_pc), .ex_illegal_o(b_ill), .illegal_cnt_o(b_cnt));

  exp_t obs_a, obs_b;
  assign obs_a = {a_valid, a_rw, a_mw, a_rsrc, a_asrc, a_asrca, a_br, a_jmp, a_jalr, a_aluop,
                  a_immsrc, a_imm, a_rd, a_rs1, a_rs2, a_f3, a_f7, a_pc, a_ill};
  assign obs_b = {b_valid, b_rw, b_mw, b_rsrc, b_asrc, b_asrca, b_br, b_jmp, b_jalr, b_aluop,
                  b_immsrc, b_imm, b_rd, b_rs1, b_rs2, b_f3, b_f7, b_pc, b_ill};

  sb_t q[$];
  exp_t cur_a, cur_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  int checks = 0, failures = 0;

  function automatic exp_t model(input logic [31:0] i, input logic [31:0] p, input bit sj);
    exp_t e;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    bit ok;
    e = '0; ok = 1'b1;
    imm_i = {{20{i[31]}}, i[31:20]};
    imm_s = {{20{i[31]}}, i[31:25], i[11:7]};
    imm_b = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    imm_j = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    imm_u = {i[31:12], 12'h000};
    e.valid = 1'b1; e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
    e.f3 = i[14:12]; e.f7 = i[30]; e.pc = p;
    case (i[6:0])
      7'h03: begin e.rw = 1; e.asrc = 1; e.rsrc = 2'b01; e.imm = imm_i; end
      7'h23: begin e.mw = 1; e.asrc = 1; e.immsrc = 3'd1; e.imm = imm_s; end
      7'h33: begin e.rw = 1; e.aluop = 2'b10; end
      7'h63: begin e.br = 1; e.immsrc = 3'd2; e.aluop = 2'b01; e.imm = imm_b; end
      7'h13: begin e.rw = 1; e.asrc = 1; e.aluop = 2'b10; e.imm = imm_i; end
      7'h6F: if (sj) begin e.rw = 1; e.jmp = 1; e.rsrc = 2'b10; e.immsrc = 3'd3; e.imm = imm_j; end
             else ok = 0;
      7'h67: if (sj) begin e.rw = 1; e.jmp = 1; e.jalr = 1; e.asrc = 1; e.rsrc = 2'b10; e.imm = imm_i; end
             else ok = 0;
      7'h37: begin e.rw = 1; e.asrc = 1; e.immsrc = 3'd4; e.aluop = 2'b11; e.imm = imm_u; end
      7'h17: begin e.rw = 1; e.asrca = 1; e.asrc = 1; e.immsrc = 3'd4; e.imm = imm_u; end
      default: ok = 0;
    endcase
    e.ill = !ok;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] p,
                      input logic st, input logic fl);
    sb_t s;
    @(negedge clk);
    id_valid = v; instr = ins; pc = p; stall = st; flush = fl;
    if (fl || (!st && !v)) begin
      cur_a = '0; cur_b = '0;
    end else if (!st) begin
      cur_a = model(ins, p, 1'b1);
      cur_b = model(ins, p, 1'b0);
      if (cur_a.ill && cnt_a != 8'hFF) cnt_a = cnt_a + 8'd1;
      if (cur_b.ill && cnt_b != 2'd3) cnt_b = cnt_b + 2'd1;
    end
    s.a = cur_a; s.b = cur_b; s.ca = cnt_a; s.cb = cnt_b;
    q.push_back(s);
    @(posedge clk); #1;
    s = q.pop_front();
    chk("slotA", 128'(obs_a), 128'(s.a));
    chk("cntA", 128'(a_cnt), 128'(s.ca));
    chk("slotB", 128'(obs_b), 128'(s.b));
    chk("cntB", 128'(b_cnt), 128'(s.cb));
  endtask

  initial begin
    rst_n = 1'b0; id_valid = 1'b0; instr = '0; pc = '0; stall = 1'b0; flush = 1'b0;
    cur_a = '0; cur_b = '0; cnt_a = '0; cnt_b = '0;
    #12;
    chk("rst_slotA", 128'(obs_a), 128'd0);
    chk("rst_cntA", 128'(a_cnt), 128'd0);
    chk("rst_slotB", 128'(obs_b), 128'd0);
    @(negedge clk); rst_n = 1'b1;

    step(1, 32'h00812283, 32'h100, 0, 0);
    chk("lw_imm", 128'(a_imm), 128'h8); chk("lw_rd", 128'(a_rd), 128'd5);
    chk("lw_rs1", 128'(a_rs1), 128'd2); chk("lw_f3", 128'(a_f3), 128'd2);
    chk("lw_rsrc", 128'(a_rsrc), 128'd1); chk("lw_pc", 128'(a_pc), 128'h100);
    step(1, 32'hFE612E23, 32'h104, 0, 0);
    chk("sw_imm", 128'(a_imm), 128'hFFFFFFFC); chk("sw_rs2", 128'(a_rs2), 128'd6);
    chk("sw_immsrc", 128'(a_immsrc), 128'd1); chk("sw_rw", 128'(a_rw), 128'd0);
    step(1, 32'h010000EF, 32'h108, 1, 0);
    chk("stall_mw", 128'(a_mw), 128'd1); chk("stall_pc", 128'(a_pc), 128'h104);
    step(1, 32'h010000EF, 32'h108, 0, 0);
    chk("jal_imm", 128'(a_imm), 128'h10); chk("jal_rd", 128'(a_rd), 128'd1);
    chk("jal_rsrc", 128'(a_rsrc), 128'd2); chk("jal_illB", 128'(b_ill), 128'd1);
    step(1, 32'h123451B7, 32'h10C, 0, 0);
    chk("lui_imm", 128'(a_imm), 128'h12345000); chk("lui_aluop", 128'(a_aluop), 128'd3);
    step(1, 32'h00001117, 32'h110, 0, 0);
    step(1, 32'h000080E7, 32'h114, 0, 0);
    step(1, 32'h00208463, 32'h118, 0, 0);
    chk("beq_imm", 128'(a_imm), 128'h8);
    step(1, 32'h002081B3, 32'h11C, 0, 0);
    step(1, 32'hFFF00093, 32'h120, 0, 0);
    chk("addi_imm", 128'(a_imm), 128'hFFFFFFFF);
    step(1, 32'h00000000, 32'h124, 0, 0);
    chk("zero_ill", 128'(a_ill), 128'd1); chk("zero_cnt", 128'(a_cnt), 128'd1);
    step(1, 32'h00000012, 32'h128, 0, 0);
    step(1, 32'h0000007F, 32'h12C, 0, 0);
    chk("sat_cntB", 128'(b_cnt), 128'd3);
    step(1, 32'h00000000, 32'h130, 1, 0);
    step(0, 32'h00000000, 32'h134, 0, 0);
    step(1, 32'h002081B3, 32'h138, 0, 0);
    step(1, 32'h002081B3, 32'h13C, 1, 1);
    chk("flush_valid", 128'(a_valid), 128'd0); chk("flush_cnt", 128'(a_cnt), 128'd3);
    step(1, 32'h00812283, 32'h140, 0, 0);

    @(negedge clk); #2; rst_n = 1'b0; #1;
    chk("mid_rst_slotA", 128'(obs_a), 128'd0);
    chk("mid_rst_cntA", 128'(a_cnt), 128'd0);
    chk("mid_rst_cntB", 128'(b_cnt), 128'd0);
    cur_a = '0; cur_b = '0; cnt_a = '0; cnt_b = '0;
    @(negedge clk); rst_n = 1'b1;
    step(1, 32'h00000000, 32'h200, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
